// File: rtl/hawk_axi_rd_arb_pkg.sv
// Shared types and constants for the hawk DRAM read-channel arbiter.
// One burst in flight at a time; state encodings are plain constants for legacy tools.
package hawk_axi_rd_arb_pkg;

  localparam int unsigned HacdAxi4DataWidth = 64;
  localparam int unsigned HacdAxi4AddrWidth = 32;
  localparam int unsigned HacdAxi4IdWidth   = 4;

  typedef logic [1:0] rd_arb_state_t;

  localparam rd_arb_state_t StIdle   = 2'd0;
  localparam rd_arb_state_t StArSend = 2'd1;
  localparam rd_arb_state_t StRWait  = 2'd2;

  localparam logic GntCpu  = 1'b0;
  localparam logic GntHawk = 1'b1;

  // A beat is inconsistent with arlen if rlast lands anywhere but beat index len.
  function automatic logic len_mismatch(input logic       last,
                                        input logic [7:0] beat_cnt,
                                        input logic [7:0] len);
    if (last) begin
      return beat_cnt != len;
    end
    return beat_cnt == len;
  endfunction

endpackage

// File: rtl/hawk_axi_rd_arb_rr.sv
// Two-input picker between the CPU and hawk AR streams.
// HAWK_PRIO = 1 gives hawk every tie; 0 alternates ties using the last grant.
module hawk_axi_rd_arb_rr
  import hawk_axi_rd_arb_pkg::*;
#(
  parameter int unsigned HAWK_PRIO = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_en,
  input  logic i_cpu_req,
  input  logic i_hawk_req,
  output logic o_gnt_cpu,
  output logic o_gnt_hawk
);

  logic r_last_grant;
  logic w_pick_hawk;

  always_comb begin
    w_pick_hawk = 1'b0;
    if (i_hawk_req && !i_cpu_req) begin
      w_pick_hawk = 1'b1;
    end else if (i_hawk_req && i_cpu_req) begin
      w_pick_hawk = (HAWK_PRIO != 0) ? 1'b1 : (r_last_grant == GntCpu);
    end
  end

  assign o_gnt_hawk = i_en & w_pick_hawk;
  assign o_gnt_cpu  = i_en & i_cpu_req & ~w_pick_hawk;

  // Starts at hawk so the CPU wins the first round-robin tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_grant <= GntHawk;
    end else if (o_gnt_cpu || o_gnt_hawk) begin
      r_last_grant <= o_gnt_hawk;
    end
  end

endmodule

// File: rtl/hawk_axi_rd_arb.sv
// Merges the CPU stall-bridge and hawk AR streams onto one DRAM AXI4 read master,
// one burst at a time, steering each R burst back to its issuer and flagging bad lengths.
module hawk_axi_rd_arb
  import hawk_axi_rd_arb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = HacdAxi4DataWidth,
  parameter int unsigned ADDR_WIDTH = HacdAxi4AddrWidth,
  parameter int unsigned ID_WIDTH   = HacdAxi4IdWidth,
  parameter int unsigned HAWK_PRIO  = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  // CPU stall bridge
  input  logic [ID_WIDTH-1:0]   i_cpu_arid,
  input  logic [ADDR_WIDTH-1:0] i_cpu_araddr,
  input  logic [7:0]            i_cpu_arlen,
  input  logic [2:0]            i_cpu_arsize,
  input  logic [1:0]            i_cpu_arburst,
  input  logic                  i_cpu_arvalid,
  output logic                  o_cpu_arready,
  output logic [ID_WIDTH-1:0]   o_cpu_rid,
  output logic [DATA_WIDTH-1:0] o_cpu_rdata,
  output logic [1:0]            o_cpu_rresp,
  output logic                  o_cpu_rlast,
  output logic                  o_cpu_rvalid,
  input  logic                  i_cpu_rready,
  // hawk control-unit master
  input  logic [ID_WIDTH-1:0]   i_hawk_arid,
  input  logic [ADDR_WIDTH-1:0] i_hawk_araddr,
  input  logic [7:0]            i_hawk_arlen,
  input  logic [2:0]            i_hawk_arsize,
  input  logic [1:0]            i_hawk_arburst,
  input  logic                  i_hawk_arvalid,
  output logic                  o_hawk_arready,
  output logic [ID_WIDTH-1:0]   o_hawk_rid,
  output logic [DATA_WIDTH-1:0] o_hawk_rdata,
  output logic [1:0]            o_hawk_rresp,
  output logic                  o_hawk_rlast,
  output logic                  o_hawk_rvalid,
  input  logic                  i_hawk_rready,
  // DRAM master
  output logic [ID_WIDTH-1:0]   o_m_axi_arid,
  output logic [ADDR_WIDTH-1:0] o_m_axi_araddr,
  output logic [7:0]            o_m_axi_arlen,
  output logic [2:0]            o_m_axi_arsize,
  output logic [1:0]            o_m_axi_arburst,
  output logic                  o_m_axi_arvalid,
  input  logic                  i_m_axi_arready,
  input  logic [ID_WIDTH-1:0]   i_m_axi_rid,
  input  logic [DATA_WIDTH-1:0] i_m_axi_rdata,
  input  logic [1:0]            i_m_axi_rresp,
  input  logic                  i_m_axi_rlast,
  input  logic                  i_m_axi_rvalid,
  output logic                  o_m_axi_rready,
  // status
  output logic                  o_owner,
  output logic                  o_busy,
  output logic                  o_len_err
);

  typedef struct packed {
    logic [ID_WIDTH-1:0]   id;
    logic [ADDR_WIDTH-1:0] addr;
    logic [7:0]            len;
    logic [2:0]            size;
    logic [1:0]            burst;
  } ar_fields_t;

  rd_arb_state_t r_state, w_state_d;
  ar_fields_t    r_ar, w_ar_d;
  logic          r_owner, w_owner_d;
  logic [7:0]    r_beat_cnt, w_beat_cnt_d;
  logic          r_len_err, w_len_err_d;

  logic w_idle;
  logic w_rwait;
  logic w_gnt_cpu;
  logic w_gnt_hawk;
  logic w_grant;
  logic w_owner_rready;
  logic w_r_hs;

  assign w_idle  = (r_state == StIdle);
  assign w_rwait = (r_state == StRWait);

  // rst_n in the enable keeps both arready low while reset is held.
  hawk_axi_rd_arb_rr #(
    .HAWK_PRIO(HAWK_PRIO)
  ) u_rr (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_en      (w_idle & rst_n),
    .i_cpu_req (i_cpu_arvalid),
    .i_hawk_req(i_hawk_arvalid),
    .o_gnt_cpu (w_gnt_cpu),
    .o_gnt_hawk(w_gnt_hawk)
  );

  assign w_grant        = w_gnt_cpu | w_gnt_hawk;
  assign o_cpu_arready  = w_gnt_cpu;
  assign o_hawk_arready = w_gnt_hawk;

  assign o_m_axi_arid    = r_ar.id;
  assign o_m_axi_araddr  = r_ar.addr;
  assign o_m_axi_arlen   = r_ar.len;
  assign o_m_axi_arsize  = r_ar.size;
  assign o_m_axi_arburst = r_ar.burst;
  assign o_m_axi_arvalid = (r_state == StArSend);

  assign w_owner_rready = r_owner ? i_hawk_rready : i_cpu_rready;
  assign o_m_axi_rready = w_rwait & w_owner_rready;
  assign w_r_hs         = o_m_axi_rready & i_m_axi_rvalid;

  // Payload fans out to both ports; only the owner's rvalid qualifies it.
  assign o_cpu_rid     = i_m_axi_rid;
  assign o_cpu_rdata   = i_m_axi_rdata;
  assign o_cpu_rresp   = i_m_axi_rresp;
  assign o_cpu_rlast   = i_m_axi_rlast;
  assign o_cpu_rvalid  = w_rwait & ~r_owner & i_m_axi_rvalid;
  assign o_hawk_rid    = i_m_axi_rid;
  assign o_hawk_rdata  = i_m_axi_rdata;
  assign o_hawk_rresp  = i_m_axi_rresp;
  assign o_hawk_rlast  = i_m_axi_rlast;
  assign o_hawk_rvalid = w_rwait & r_owner & i_m_axi_rvalid;

  assign o_busy    = ~w_idle | w_grant;
  assign o_owner   = w_grant ? w_gnt_hawk : r_owner;
  assign o_len_err = r_len_err;

  always_comb begin
    w_state_d    = r_state;
    w_ar_d       = r_ar;
    w_owner_d    = r_owner;
    w_beat_cnt_d = r_beat_cnt;
    w_len_err_d  = r_len_err;
    unique case (r_state)
      StIdle: begin
        if (w_grant) begin
          w_owner_d    = w_gnt_hawk;
          w_ar_d.id    = w_gnt_hawk ? i_hawk_arid    : i_cpu_arid;
          w_ar_d.addr  = w_gnt_hawk ? i_hawk_araddr  : i_cpu_araddr;
          w_ar_d.len   = w_gnt_hawk ? i_hawk_arlen   : i_cpu_arlen;
          w_ar_d.size  = w_gnt_hawk ? i_hawk_arsize  : i_cpu_arsize;
          w_ar_d.burst = w_gnt_hawk ? i_hawk_arburst : i_cpu_arburst;
          w_state_d    = StArSend;
        end
      end
      StArSend: begin
        if (i_m_axi_arready) begin
          w_beat_cnt_d = 8'd0;
          w_state_d    = StRWait;
        end
      end
      StRWait: begin
        if (w_r_hs) begin
          w_beat_cnt_d = r_beat_cnt + 8'd1;
          if (len_mismatch(i_m_axi_rlast, r_beat_cnt, r_ar.len)) begin
            w_len_err_d = 1'b1;
          end
          // Only rlast ends the burst, even when the length disagrees.
          if (i_m_axi_rlast) begin
            w_state_d = StIdle;
          end
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= StIdle;
      r_ar       <= '0;
      r_owner    <= GntCpu;
      r_beat_cnt <= 8'd0;
      r_len_err  <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_ar       <= w_ar_d;
      r_owner    <= w_owner_d;
      r_beat_cnt <= w_beat_cnt_d;
      r_len_err  <= w_len_err_d;
    end
  end

endmodule

// File: tb/tb_hawk_axi_rd_arb.sv
// Bench for hawk_axi_rd_arb: instance 0 has HAWK_PRIO = 1, instance 1 is round-robin.
// A cycle table drives instance 0; hand sequences cover ties, stalls, resets and bad lengths.
module tb_hawk_axi_rd_arb;
  import hawk_axi_rd_arb_pkg::*;

  localparam int unsigned DW = HacdAxi4DataWidth;
  localparam int unsigned AW = HacdAxi4AddrWidth;
  localparam int unsigned IW = HacdAxi4IdWidth;
  localparam int NV = 19;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0][IW-1:0] cpu_arid, hawk_arid, cpu_rid, hawk_rid, m_arid, m_rid;
  logic [1:0][AW-1:0] cpu_araddr, hawk_araddr, m_araddr;
  logic [1:0][7:0]    cpu_arlen, hawk_arlen, m_arlen;
  logic [1:0][2:0]    cpu_arsize, hawk_arsize, m_arsize;
  logic [1:0][1:0]    cpu_arburst, hawk_arburst, m_arburst;
  logic [1:0][1:0]    cpu_rresp, hawk_rresp, m_rresp;
  logic [1:0][DW-1:0] cpu_rdata, hawk_rdata, m_rdata;
  logic [1:0] cpu_arvalid, cpu_arready, cpu_rlast, cpu_rvalid, cpu_rready;
  logic [1:0] hawk_arvalid, hawk_arready, hawk_rlast, hawk_rvalid, hawk_rready;
  logic [1:0] m_arvalid, m_arready, m_rlast, m_rvalid, m_rready;
  logic [1:0] owner, busy, len_err;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    hawk_axi_rd_arb #(
      .DATA_WIDTH(DW),
      .ADDR_WIDTH(AW),
      .ID_WIDTH  (IW),
      .HAWK_PRIO ((g == 0) ? 1 : 0)
    ) u_dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .i_cpu_arid     (cpu_arid[g]),
      .i_cpu_araddr   (cpu_araddr[g]),
      .i_cpu_arlen    (cpu_arlen[g]),
      .i_cpu_arsize   (cpu_arsize[g]),
      .i_cpu_arburst  (cpu_arburst[g]),
      .i_cpu_arvalid  (cpu_arvalid[g]),
      .o_cpu_arready  (cpu_arready[g]),
      .o_cpu_rid      (cpu_rid[g]),
      .o_cpu_rdata    (cpu_rdata[g]),
      .o_cpu_rresp    (cpu_rresp[g]),
      .o_cpu_rlast    (cpu_rlast[g]),
      .o_cpu_rvalid   (cpu_rvalid[g]),
      .i_cpu_rready   (cpu_rready[g]),
      .i_hawk_arid    (hawk_arid[g]),
      .i_hawk_araddr  (hawk_araddr[g]),
      .i_hawk_arlen   (hawk_arlen[g]),
      .i_hawk_arsize  (hawk_arsize[g]),
      .i_hawk_arburst (hawk_arburst[g]),
      .i_hawk_arvalid (hawk_arvalid[g]),
      .o_hawk_arready (hawk_arready[g]),
      .o_hawk_rid     (hawk_rid[g]),
      .o_hawk_rdata   (hawk_rdata[g]),
      .o_hawk_rresp   (hawk_rresp[g]),
      .o_hawk_rlast   (hawk_rlast[g]),
      .o_hawk_rvalid  (hawk_rvalid[g]),
      .i_hawk_rready  (hawk_rready[g]),
      .o_m_axi_arid   (m_arid[g]),
      .o_m_axi_araddr (m_araddr[g]),
      .o_m_axi_arlen  (m_arlen[g]),
      .o_m_axi_arsize (m_arsize[g]),
      .o_m_axi_arburst(m_arburst[g]),
      .o_m_axi_arvalid(m_arvalid[g]),
      .i_m_axi_arready(m_arready[g]),
      .i_m_axi_rid    (m_rid[g]),
      .i_m_axi_rdata  (m_rdata[g]),
      .i_m_axi_rresp  (m_rresp[g]),
      .i_m_axi_rlast  (m_rlast[g]),
      .i_m_axi_rvalid (m_rvalid[g]),
      .o_m_axi_rready (m_rready[g]),
      .o_owner        (owner[g]),
      .o_busy         (busy[g]),
      .o_len_err      (len_err[g])
    );
  end

  // stim: {cpu_arvalid, hawk_arvalid, m_arready, m_rvalid, m_rlast, cpu_rready, hawk_rready}
  // exp:  {cpu_arready, hawk_arready, m_arvalid, m_rready, cpu_rvalid, hawk_rvalid,
  //        busy, owner, len_err}
  typedef struct packed {
    logic [6:0]  stim;
    logic [8:0]  exp;
    logic [31:0] addr;
  } vec_t;

  vec_t vecs [NV];
  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string name, input int d);
    chk(name, {cpu_arready[d], hawk_arready[d], m_arvalid[d], m_rready[d], cpu_rvalid[d],
               hawk_rvalid[d], busy[d], owner[d], len_err[d]}, 9'b0);
  endtask

  // Entered just after the negedge of the first AR_SEND cycle; returns at the negedge
  // of the cycle after the rlast handshake. rlast is driven on the final beat only.
  task automatic serve(input int d, input logic hawk_own, input int nbeats, input int stall,
                       input logic [AW-1:0] exp_addr, input logic [7:0] exp_len);
    logic [DW-1:0] exp_data;
    logic [IW-1:0] exp_rid;
    for (int s = 0; s < stall; s++) begin
      m_arready[d] = 1'b0;
      #1;
      chk($sformatf("d%0d stall%0d arvalid", d, s), m_arvalid[d], 1'b1);
      chk($sformatf("d%0d stall%0d araddr", d, s), m_araddr[d], exp_addr);
      chk($sformatf("d%0d stall%0d arlen", d, s), m_arlen[d], exp_len);
      chk($sformatf("d%0d stall%0d arready", d, s), {cpu_arready[d], hawk_arready[d]}, 2'b00);
      @(negedge clk);
    end
    m_arready[d] = 1'b1;
    #1;
    chk($sformatf("d%0d ar arvalid", d), m_arvalid[d], 1'b1);
    chk($sformatf("d%0d ar araddr", d), m_araddr[d], exp_addr);
    chk($sformatf("d%0d ar arid", d), m_arid[d], hawk_own ? hawk_arid[d] : cpu_arid[d]);
    chk($sformatf("d%0d ar size/burst", d), {m_arsize[d], m_arburst[d]}, {3'd3, 2'b01});
    @(negedge clk);
    m_arready[d] = 1'b0;
    for (int b = 0; b < nbeats; b++) begin
      exp_data     = {48'hBEEF_0000_0000, 16'(b)};
      exp_rid      = IW'(b + 5);
      m_rdata[d]   = exp_data;
      m_rid[d]     = exp_rid;
      m_rresp[d]   = 2'b00;
      m_rvalid[d]  = 1'b1;
      m_rlast[d]   = (b == nbeats - 1);
      #1;
      chk($sformatf("d%0d beat%0d rvalid", d, b), {cpu_rvalid[d], hawk_rvalid[d]},
          hawk_own ? 2'b01 : 2'b10);
      chk($sformatf("d%0d beat%0d rdata", d, b), hawk_own ? hawk_rdata[d] : cpu_rdata[d],
          exp_data);
      chk($sformatf("d%0d beat%0d rid/resp/last", d, b),
          hawk_own ? {hawk_rid[d], hawk_rresp[d], hawk_rlast[d]}
                   : {cpu_rid[d], cpu_rresp[d], cpu_rlast[d]},
          {exp_rid, 2'b00, (b == nbeats - 1) ? 1'b1 : 1'b0});
      chk($sformatf("d%0d beat%0d rready/busy", d, b), {m_rready[d], busy[d]}, 2'b11);
      @(negedge clk);
    end
    m_rvalid[d] = 1'b0;
    m_rlast[d]  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{7'b1000000, 9'b100000100, 32'h0};
    vecs[1]  = '{7'b0001010, 9'b001000100, 32'h8000_1000};
    vecs[2]  = '{7'b0010000, 9'b001000100, 32'h8000_1000};
    vecs[3]  = '{7'b0001010, 9'b000110100, 32'h0};
    vecs[4]  = '{7'b0001010, 9'b000110100, 32'h0};
    vecs[5]  = '{7'b0101000, 9'b000010100, 32'h0};
    vecs[6]  = '{7'b0001010, 9'b000110100, 32'h0};
    vecs[7]  = '{7'b0001110, 9'b000110100, 32'h0};
    vecs[8]  = '{7'b0000000, 9'b000000000, 32'h0};
    vecs[9]  = '{7'b0100000, 9'b010000110, 32'h0};
    vecs[10] = '{7'b0011001, 9'b001000110, 32'h4000_0040};
    vecs[11] = '{7'b0001101, 9'b000101110, 32'h0};
    vecs[12] = '{7'b1000000, 9'b100000101, 32'h0};
    vecs[13] = '{7'b0010000, 9'b001000101, 32'h8000_1000};
    vecs[14] = '{7'b0001010, 9'b000110101, 32'h0};
    vecs[15] = '{7'b0001010, 9'b000110101, 32'h0};
    vecs[16] = '{7'b0001010, 9'b000110101, 32'h0};
    vecs[17] = '{7'b0001110, 9'b000110101, 32'h0};
    vecs[18] = '{7'b0000000, 9'b000000001, 32'h0};

    cpu_arvalid = '0; hawk_arvalid = '0; cpu_rready = '1; hawk_rready = '1;
    m_arready = '0; m_rvalid = '0; m_rlast = '0; m_rdata = '0; m_rid = '0; m_rresp = '0;
    for (int d = 0; d < 2; d++) begin
      cpu_arid[d]     = 4'h3;
      cpu_araddr[d]   = 32'h8000_1000;
      cpu_arlen[d]    = (d == 0) ? 8'd3 : 8'd0;
      cpu_arsize[d]   = 3'd3;
      cpu_arburst[d]  = 2'b01;
      hawk_arid[d]    = 4'h9;
      hawk_araddr[d]  = 32'h4000_0040;
      hawk_arlen[d]   = (d == 0) ? 8'd1 : 8'd0;
      hawk_arsize[d]  = 3'd3;
      hawk_arburst[d] = 2'b01;
    end

    // Reset values, during and just after reset
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) chk_all_zero($sformatf("d%0d in reset", d), d);
    rst_n = 1'b1;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk_all_zero($sformatf("d%0d after reset", d), d);
      chk($sformatf("d%0d after reset araddr", d), m_araddr[d], 32'h0);
    end

    // Cycle table: CPU read len 3, then hawk read with early rlast, then CPU read len 3
    for (int i = 0; i < NV; i++) begin
      {cpu_arvalid[0], hawk_arvalid[0], m_arready[0], m_rvalid[0], m_rlast[0],
       cpu_rready[0], hawk_rready[0]} = vecs[i].stim;
      m_rdata[0] = {32'hD0D0_0000, 32'(i)};
      #1;
      chk($sformatf("vec%0d outs", i),
          {cpu_arready[0], hawk_arready[0], m_arvalid[0], m_rready[0], cpu_rvalid[0],
           hawk_rvalid[0], busy[0], owner[0], len_err[0]}, vecs[i].exp);
      if (vecs[i].exp[6]) chk($sformatf("vec%0d araddr", i), m_araddr[0], vecs[i].addr);
      if (vecs[i].exp[4]) chk($sformatf("vec%0d cpu_rdata", i), cpu_rdata[0],
                              {32'hD0D0_0000, 32'(i)});
      if (vecs[i].exp[3]) chk($sformatf("vec%0d hawk_rdata", i), hawk_rdata[0],
                              {32'hD0D0_0000, 32'(i)});
      @(negedge clk);
    end
    cpu_rready[0] = 1'b1;
    hawk_rready[0] = 1'b1;

    // Fixed priority tie: hawk first, CPU in the cycle after hawk's rlast
    cpu_arvalid[0] = 1'b1;
    hawk_arvalid[0] = 1'b1;
    #1;
    chk("prio tie grant", {cpu_arready[0], hawk_arready[0], owner[0]}, 3'b011);
    @(negedge clk);
    hawk_arvalid[0] = 1'b0;
    #1;
    chk("prio cpu waits", cpu_arready[0], 1'b0);
    serve(0, 1'b1, 2, 0, 32'h4000_0040, 8'd1);
    #1;
    chk("prio cpu next", {cpu_arready[0], hawk_arready[0], owner[0]}, 3'b100);

    // CPU burst with 5 cycles of arready stall while hawk requests
    @(negedge clk);
    cpu_arvalid[0] = 1'b0;
    hawk_arvalid[0] = 1'b1;
    serve(0, 1'b0, 4, 5, 32'h8000_1000, 8'd3);
    #1;
    chk("hawk after stall", {cpu_arready[0], hawk_arready[0]}, 2'b01);
    @(negedge clk);
    hawk_arvalid[0] = 1'b0;
    serve(0, 1'b1, 2, 0, 32'h4000_0040, 8'd1);
    #1;
    chk("d0 idle", busy[0], 1'b0);

    // Round-robin ties on instance 1: C, H, C, H, C, H
    cpu_arvalid[1] = 1'b1;
    hawk_arvalid[1] = 1'b1;
    for (int k = 0; k < 6; k++) begin
      #1;
      chk($sformatf("rr grant%0d", k), {cpu_arready[1], hawk_arready[1]},
          (k % 2 == 0) ? 2'b10 : 2'b01);
      @(negedge clk);
      if (k == 5) begin
        cpu_arvalid[1] = 1'b0;
        hawk_arvalid[1] = 1'b0;
      end
      serve(1, (k % 2 == 1), 1, 0, (k % 2 == 1) ? 32'h4000_0040 : 32'h8000_1000, 8'd0);
    end
    #1;
    chk("rr len_err", len_err[1], 1'b0);

    // Reset in R_WAIT, then a clean CPU read
    @(negedge clk);
    cpu_arvalid[0] = 1'b1;
    #1;
    chk("rst grant", cpu_arready[0], 1'b1);
    @(negedge clk);
    cpu_arvalid[0] = 1'b0;
    m_arready[0] = 1'b1;
    @(negedge clk);
    m_arready[0] = 1'b0;
    m_rvalid[0] = 1'b1;
    @(negedge clk);
    #1;
    chk("pre-reset rvalid", {cpu_rvalid[0], busy[0], len_err[0]}, 3'b111);
    cpu_arvalid[0] = 1'b1;
    cpu_arlen[0] = 8'd0;
    cpu_araddr[0] = 32'h8000_2000;
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("mid-burst reset", 0);
    m_rvalid[0] = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post-reset grant", {cpu_arready[0], busy[0]}, 2'b11);
    @(negedge clk);
    cpu_arvalid[0] = 1'b0;
    serve(0, 1'b0, 1, 0, 32'h8000_2000, 8'd0);
    #1;
    chk("post-reset read done", {busy[0], len_err[0]}, 2'b00);

    // Late rlast: arlen 1 but rlast on beat 2
    @(negedge clk);
    cpu_arlen[0] = 8'd1;
    cpu_arvalid[0] = 1'b1;
    #1;
    chk("late grant", cpu_arready[0], 1'b1);
    @(negedge clk);
    cpu_arvalid[0] = 1'b0;
    serve(0, 1'b0, 3, 0, 32'h8000_2000, 8'd1);
    #1;
    chk("late rlast end", {busy[0], len_err[0]}, 2'b01);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
